// File: rtl/traffic_ctrl.sv
// Two-road intersection controller with optional pedestrian walk phase.
// Moore FSM timed by a single phase counter that clears on every state change.
module traffic_ctrl #(
  parameter int GMIN  = 4,
  parameter int GMAX  = 8,
  parameter int YEL   = 2,
  parameter int RED   = 1,
  parameter int WALK  = 3,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic [2:0] phase
);

  // state | meaning
  // AG    | road A green, B red
  // AY    | road A yellow, B red
  // AR    | all red after A
  // BG    | road B green, A red
  // BY    | road B yellow, A red
  // BR    | all red after B
  // PW    | all red, pedestrian walk
  localparam logic [2:0] AG = 3'd0;
  localparam logic [2:0] AY = 3'd1;
  localparam logic [2:0] AR = 3'd2;
  localparam logic [2:0] BG = 3'd3;
  localparam logic [2:0] BY = 3'd4;
  localparam logic [2:0] BR = 3'd5;
  localparam logic [2:0] PW = 3'd6;

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GMIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GMAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YEL - 1);
  localparam logic [CNT_W-1:0] RED_M1  = CNT_W'(RED - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK - 1);

  localparam logic [1:0] L_GRN = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_RED = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             next_b_q, next_b_d;
  logic             pend_eff, dem_a, dem_b, enter_pw;

  // A request on the current cycle already counts as demand at this edge.
  assign pend_eff = pend_q | ped;
  assign dem_a    = ta | pend_eff;
  assign dem_b    = tb | pend_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= AG;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      next_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      next_b_q <= next_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AG: if (dem_b && ((cnt_q >= GMIN_M1 && !ta) || cnt_q == GMAX_M1)) state_d = AY;
      AY: if (cnt_q == YEL_M1) state_d = AR;
      AR: if (cnt_q == RED_M1) state_d = pend_eff ? PW : BG;
      BG: if (dem_a && ((cnt_q >= GMIN_M1 && !tb) || cnt_q == GMAX_M1)) state_d = BY;
      BY: if (cnt_q == YEL_M1) state_d = BR;
      BR: if (cnt_q == RED_M1) state_d = pend_eff ? PW : AG;
      PW: if (cnt_q == WALK_M1) state_d = next_b_q ? BG : AG;
      default: state_d = AG;
    endcase
  end

  always_comb begin
    enter_pw = (state_d == PW) && (state_q != PW);
    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == AG || state_q == BG) && cnt_q == GMAX_M1)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);
    pend_d   = ped | (pend_q & ~enter_pw);
    next_b_d = enter_pw ? (state_q == AR) : next_b_q;
  end

  always_comb begin
    la    = L_RED;
    lb    = L_RED;
    walk  = 1'b0;
    phase = state_q;
    case (state_q)
      AG: la = L_GRN;
      AY: la = L_YEL;
      BG: lb = L_GRN;
      BY: lb = L_YEL;
      PW: walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl with default parameters.
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       reset, ta, tb, ped;
  logic [1:0] la, lb;
  logic       walk;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  traffic_ctrl dut (
    .clk(clk), .reset(reset), .ta(ta), .tb(tb), .ped(ped),
    .la(la), .lb(lb), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_la(input logic [2:0] p);
    case (p)
      3'd0: return 2'b00;
      3'd1: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] exp_lb(input logic [2:0] p);
    case (p)
      3'd3: return 2'b00;
      3'd4: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic look(input string tag, input logic [2:0] p);
    chk({tag, "_phase"}, 32'(phase), 32'(p));
    chk({tag, "_la"}, 32'(la), 32'(exp_la(p)));
    chk({tag, "_lb"}, 32'(lb), 32'(exp_lb(p)));
    chk({tag, "_walk"}, 32'(walk), 32'(p == 3'd6));
  endtask

  task automatic step_chk(input string tag, input logic [2:0] p);
    step();
    look(tag, p);
  endtask

  // Free-running A/B cycle starting at BG cnt=0: BG8 BY2 BR1 AG8 AY2 AR1.
  function automatic logic [2:0] t2_phase(input int i);
    int m;
    m = i % 22;
    if (m < 8) return 3'd3;
    if (m < 10) return 3'd4;
    if (m < 11) return 3'd5;
    if (m < 19) return 3'd0;
    if (m < 21) return 3'd1;
    return 3'd2;
  endfunction

  always @(negedge clk)
    if (reset === 1'b0) chk("never_both_go", 32'(la != 2'b10 && lb != 2'b10), 32'd0);

  initial begin
    logic [2:0] t1 [8];
    logic [2:0] t4 [9];
    logic [2:0] t6a [5];
    logic [2:0] t6b [13];
    t1  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
    t4  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd3};
    t6a = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    t6b = '{3'd6, 3'd6, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd0};

    reset = 1'b1; ta = 1'b0; tb = 1'b0; ped = 1'b0;
    step();
    step();
    look("reset", 3'd0);
    chk("reset_cnt", 32'(dut.cnt_q), 32'd0);
    chk("reset_pend", 32'(dut.pend_q), 32'd0);
    chk("reset_nextb", 32'(dut.next_b_q), 32'd0);

    // 1: B demand only, A green for exactly GMIN
    reset = 1'b0; tb = 1'b1;
    look("t1_0", t1[0]);
    for (int i = 1; i < 8; i++) step_chk("t1", t1[i]);

    // 2: both roads busy, greens run to GMAX, 22-cycle period
    ta = 1'b1;
    for (int k = 1; k <= 55; k++) step_chk("t2", t2_phase(k));

    // 3: no demand, AG holds with saturated counter
    ta = 1'b0; tb = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      chk("t3_phase", 32'(phase), 32'd0);
      chk("t3_la", 32'(la), 32'd0);
    end
    chk("t3_cnt_sat", 32'(dut.cnt_q), 32'd7);

    // 4: single-cycle ped pulse in AG cycle 1
    reset = 1'b1;
    step();
    reset = 1'b0;
    ped = 1'b1;
    step_chk("t4_ped", 3'd0);
    chk("t4_pend_set", 32'(dut.pend_q), 32'd1);
    ped = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step_chk("t4", t4[i]);
      if (t4[i] == 3'd6) chk("t4_pend_clr", 32'(dut.pend_q), 32'd0);
    end

    // 5: reset during BY, then illegal state recovery
    ta = 1'b1;
    for (int i = 0; i < 3; i++) step_chk("t5_bg", 3'd3);
    step_chk("t5_by0", 3'd4);
    step_chk("t5_by1", 3'd4);
    reset = 1'b1; ta = 1'b0;
    step_chk("t5_reset", 3'd0);
    chk("t5_reset_cnt", 32'(dut.cnt_q), 32'd0);
    reset = 1'b0;
    force dut.state_q = 3'd7;
    #1;
    chk("t5_forced", 32'(phase), 32'd7);
    release dut.state_q;
    step_chk("t5_illegal", 3'd0);
    chk("t5_illegal_cnt", 32'(dut.cnt_q), 32'd0);

    // 6: ped held on the edge entering PW keeps a second walk pending
    ped = 1'b1;
    step_chk("t6_ped", 3'd0);
    ped = 1'b0;
    for (int i = 0; i < 5; i++) step_chk("t6a", t6a[i]);
    ped = 1'b1;
    step_chk("t6_enter", 3'd6);
    chk("t6_pend_kept", 32'(dut.pend_q), 32'd1);
    ped = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step_chk("t6b", t6b[i]);
      if (i == 9) chk("t6_pend_clr", 32'(dut.pend_q), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
